// File: rtl/acc_ctrl.sv
// acc_ctrl -- multi-cycle control sequencer for the 8-bit accumulator CPU.
//
// Fetches the 8-bit instruction at pc and decodes it. It then drives the
// accumulator, ALU and register-file controls for one EXEC cycle. Every
// instruction takes three cycles: FETCH, DECODE and EXEC. HLT takes two
// cycles (FETCH, DECODE) and then parks the sequencer in HALT.
//
// Ports:
//   clk       in   system clock, rising edge
//   CLB       in   asynchronous active-low reset
//   run       in   start request, only looked at in IDLE
//   instr_in  in   [7:0] instruction word at address pc
//   acc_zero  in   accumulator == 0, sampled during EXEC of JZ
//   pc        out  [7:0] program counter / instruction address
//   loadAcc   out  accumulator load strobe
//   sel_acc   out  [1:0] accumulator source: 00 ALU, 10 register, 11 immediate
//   imm       out  [3:0] immediate value (ir[3:0])
//   alu_op    out  [1:0] 00 ADD, 01 SUB, 10 AND, 11 OR
//   reg_sel   out  [3:0] register-file index (ir[3:0])
//   loadReg   out  register-file write strobe
//   halted    out  high while in HALT
//   illegal   out  sticky undefined-opcode flag
//
// Build option: define ACC_CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes
// (0xA-0xE). A trapped opcode sets illegal and halts with pc left at the
// trapping instruction. Without the macro, undefined opcodes run as NOP and
// illegal is tied low.

module acc_ctrl (
  input  logic       clk,
  input  logic       CLB,
  input  logic       run,
  input  logic [7:0] instr_in,
  input  logic       acc_zero,
  output logic [7:0] pc,
  output logic       loadAcc,
  output logic [1:0] sel_acc,
  output logic [3:0] imm,
  output logic [1:0] alu_op,
  output logic [3:0] reg_sel,
  output logic       loadReg,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;

  logic [3:0] op;
  logic [3:0] arg;
  logic       op_undef;

  assign op       = ir_q[7:4];
  assign arg      = ir_q[3:0];
  assign op_undef = (op >= 4'hA) && (op <= 4'hE);

`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  logic trap_now;

  assign trap_now = (state_q == S_DECODE) && op_undef;
  assign illegal  = illegal_q;
`else
  logic trap_now;

  assign trap_now = 1'b0;
  assign illegal  = 1'b0;
`endif

  // State, pc and ir registers
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state_q <= S_IDLE;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  // illegal stays set until reset once any trap has been seen.
  always_comb begin
    illegal_d = illegal_q | trap_now;
  end

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`endif

  // Next-state logic. pc is written only when EXEC ends, so it stays stable
  // through FETCH and DECODE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = instr_in;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op == OP_HLT || trap_now) state_d = S_HALT;
        else                          state_d = S_EXEC;
      end
      S_EXEC: begin
        // acc_zero still shows the accumulator from before this edge.
        if (op == OP_JMP || (op == OP_JZ && acc_zero)) pc_d = {4'b0000, arg};
        else                                           pc_d = pc_q + 8'd1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: they depend only on the state and ir.
  always_comb begin
    loadAcc = 1'b0;
    loadReg = 1'b0;
    sel_acc = 2'b00;
    alu_op  = 2'b00;
    imm     = arg;
    reg_sel = arg;
    halted  = (state_q == S_HALT);
    if (state_q == S_EXEC) begin
      unique case (op)
        OP_LDI: begin
          loadAcc = 1'b1;
          sel_acc = 2'b11;
        end
        OP_LDR: begin
          loadAcc = 1'b1;
          sel_acc = 2'b10;
        end
        OP_STR: begin
          loadReg = 1'b1;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          loadAcc = 1'b1;
          sel_acc = 2'b00;
          alu_op  = op[1:0];
        end
        default: begin
          // NOP, JMP, JZ and non-trapped undefined opcodes assert no strobes.
          loadAcc = 1'b0;
        end
      endcase
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl. Instruction memory lives in the bench
// and feeds instr_in from mem[pc]. A reference model works at the level of
// whole instructions: for each opcode it gives the expected EXEC strobes,
// the next pc and whether the sequencer halts.

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) passes++; \
    else begin \
      fails++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end

module tb_acc_ctrl;

  logic       clk = 1'b0;
  logic       CLB = 1'b0;
  logic       run = 1'b0;
  logic [7:0] instr_in;
  logic       acc_zero = 1'b0;
  logic [7:0] pc;
  logic       loadAcc;
  logic [1:0] sel_acc;
  logic [3:0] imm;
  logic [1:0] alu_op;
  logic [3:0] reg_sel;
  logic       loadReg;
  logic       halted;
  logic       illegal;

  logic [7:0] mem [256];
  logic [7:0] exp_pc;
  logic       exp_ill;
  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;
  bit         done   = 1'b0;

`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  acc_ctrl dut (
    .clk      (clk),
    .CLB      (CLB),
    .run      (run),
    .instr_in (instr_in),
    .acc_zero (acc_zero),
    .pc       (pc),
    .loadAcc  (loadAcc),
    .sel_acc  (sel_acc),
    .imm      (imm),
    .alu_op   (alu_op),
    .reg_sel  (reg_sel),
    .loadReg  (loadReg),
    .halted   (halted),
    .illegal  (illegal)
  );

  assign instr_in = mem[pc];

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    checks++;
    if (!done) begin
      fails++;
      $error("FAIL watchdog expired: stimulus did not complete");
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
    end else begin
      passes++;
    end
  end

  // Reference model for one instruction.
  task automatic model(input logic [7:0] instr, input logic az, input logic [7:0] cur_pc,
                       output logic la, output logic lr, output logic [1:0] sel,
                       output logic [1:0] alu, output logic [7:0] nxt,
                       output logic hlt, output logic ill);
    int op;
    int arg;
    op  = int'(instr) / 16;
    arg = int'(instr) % 16;
    la  = 1'b0;
    lr  = 1'b0;
    sel = 2'b00;
    alu = 2'b00;
    hlt = 1'b0;
    ill = 1'b0;
    nxt = 8'((int'(cur_pc) + 1) % 256);
    if (op == 1) begin
      la  = 1'b1;
      sel = 2'b11;
    end else if (op == 2) begin
      la  = 1'b1;
      sel = 2'b10;
    end else if (op == 3) begin
      lr = 1'b1;
    end else if (op >= 4 && op <= 7) begin
      la  = 1'b1;
      alu = 2'(op - 4);
    end else if (op == 8 || (op == 9 && az)) begin
      nxt = 8'(arg);
    end else if (op == 15) begin
      hlt = 1'b1;
      nxt = cur_pc;
    end else if (op >= 10 && op <= 14 && TRAP) begin
      hlt = 1'b1;
      ill = 1'b1;
      nxt = cur_pc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    logic [24:0] rst_vec;
    @(negedge clk);
    CLB = 1'b0;
    run = 1'b0;
    #2;
    rst_vec = {pc, loadAcc, loadReg, sel_acc, alu_op, imm, reg_sel, halted, illegal};
    checks++;
    if (rst_vec !== 25'd0) begin
      fails++;
      $error("FAIL reset_state observed=%0h expected=0", rst_vec);
    end else begin
      passes++;
    end
    `CHK("reset_pc", pc, 8'h00)
    `CHK("reset_loadAcc", loadAcc, 1'b0)
    `CHK("reset_loadReg", loadReg, 1'b0)
    `CHK("reset_sel_acc", sel_acc, 2'b00)
    `CHK("reset_alu_op", alu_op, 2'b00)
    `CHK("reset_imm", imm, 4'h0)
    `CHK("reset_reg_sel", reg_sel, 4'h0)
    `CHK("reset_halted", halted, 1'b0)
    `CHK("reset_illegal", illegal, 1'b0)
    @(negedge clk);
    CLB     = 1'b1;
    exp_pc  = 8'h00;
    exp_ill = 1'b0;
  endtask

  // Pulse run for one edge. On return the DUT is in the first FETCH.
  task automatic start();
    @(posedge clk);
    #1;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Enter in FETCH and run one instruction. On return the DUT is in the
  // next FETCH, or in HALT when hlt_o is set. az_mode < 0 picks acc_zero
  // at random.
  task automatic run_instr(input int az_mode, output bit hlt_o);
    logic       la, lr, hlt, ill, az;
    logic [1:0] sel, alu;
    logic [7:0] instr, nxt;
    logic [3:0] arg;
    instr = mem[exp_pc];
    arg   = instr[3:0];
    az    = (az_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(az_mode);
    model(instr, az, exp_pc, la, lr, sel, alu, nxt, hlt, ill);
    `CHK("fetch_pc", pc, exp_pc)
    `CHK("fetch_loadAcc", loadAcc, 1'b0)
    `CHK("fetch_loadReg", loadReg, 1'b0)
    `CHK("fetch_halted", halted, 1'b0)
    tick();
    `CHK("decode_pc", pc, exp_pc)
    `CHK("decode_loadAcc", loadAcc, 1'b0)
    `CHK("decode_loadReg", loadReg, 1'b0)
    `CHK("decode_sel_acc", sel_acc, 2'b00)
    `CHK("decode_alu_op", alu_op, 2'b00)
    `CHK("decode_imm", imm, arg)
    `CHK("decode_reg_sel", reg_sel, arg)
    acc_zero = az;
    tick();
    if (hlt) begin
      exp_ill = exp_ill | ill;
      `CHK("halt_halted", halted, 1'b1)
      `CHK("halt_pc", pc, exp_pc)
      `CHK("halt_illegal", illegal, exp_ill)
      `CHK("halt_loadAcc", loadAcc, 1'b0)
      `CHK("halt_loadReg", loadReg, 1'b0)
      hlt_o = 1'b1;
      return;
    end
    `CHK("exec_loadAcc", loadAcc, la)
    `CHK("exec_loadReg", loadReg, lr)
    `CHK("exec_sel_acc", sel_acc, sel)
    `CHK("exec_alu_op", alu_op, alu)
    `CHK("exec_reg_sel", reg_sel, arg)
    `CHK("exec_imm", imm, arg)
    `CHK("exec_pc", pc, exp_pc)
    `CHK("exec_illegal", illegal, exp_ill)
    `CHK("exec_halted", halted, 1'b0)
    exp_pc = nxt;
    tick();
    hlt_o = 1'b0;
  endtask

  initial begin
    bit h;

    // Step 1: reset, then check that nothing moves while run is low.
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h15;
    mem[1] = 8'h33;
    mem[2] = 8'hF0;
    do_reset();
    repeat (3) tick();
    `CHK("idle_pc", pc, 8'h00)
    `CHK("idle_imm", imm, 4'h0)
    `CHK("idle_halted", halted, 1'b0)

    // Step 2: LDI 5 ; STR R3 ; HLT. HALT must hold while run is high.
    start();
    run_instr(0, h);
    run_instr(0, h);
    run_instr(0, h);
    `CHK("prog1_halted", h, 1'b1)
    `CHK("prog1_pc", pc, 8'h02)
    run = 1'b1;
    repeat (4) tick();
    run = 1'b0;
    `CHK("halt_absorb_halted", halted, 1'b1)
    `CHK("halt_absorb_pc", pc, 8'h02)

    // Step 3: ALU ops on R2, both JZ outcomes, JMP, then an undefined opcode.
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h42;
    mem[8'h01] = 8'h52;
    mem[8'h02] = 8'h62;
    mem[8'h03] = 8'h72;
    mem[8'h04] = 8'h9A;
    mem[8'h0A] = 8'h9A;
    mem[8'h0B] = 8'h87;
    mem[8'h07] = 8'hA0;
    do_reset();
    start();
    for (int i = 0; i < 4; i++) run_instr(0, h);
    run_instr(1, h);
    `CHK("jz_taken_pc", pc, 8'h0A)
    run_instr(0, h);
    `CHK("jz_not_taken_pc", pc, 8'h0B)
    run_instr(0, h);
    `CHK("jmp_pc", pc, 8'h07)
    run_instr(0, h);
    if (TRAP) begin
      `CHK("undef_trap_halted", halted, 1'b1)
      `CHK("undef_trap_illegal", illegal, 1'b1)
      `CHK("undef_trap_pc", pc, 8'h07)
    end else begin
      `CHK("undef_nop_pc", pc, 8'h08)
      `CHK("undef_nop_illegal", illegal, 1'b0)
    end

    // Step 4: 256 NOPs walk pc all the way around, from 0xFF back to 0x00.
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    do_reset();
    start();
    for (int i = 0; i < 256; i++) run_instr(-1, h);
    `CHK("wrap_pc", pc, 8'h00)

    // Step 5: reset asserted during the EXEC cycle of LDI.
    mem[0] = 8'h15;
    do_reset();
    start();
    tick();
    tick();
    `CHK("midexec_loadAcc_before", loadAcc, 1'b1)
    #2;
    CLB = 1'b0;
    #1;
    `CHK("midexec_loadAcc_after", loadAcc, 1'b0)
    `CHK("midexec_pc", pc, 8'h00)
    `CHK("midexec_sel_acc", sel_acc, 2'b00)
    `CHK("midexec_imm", imm, 4'h0)
    @(negedge clk);
    CLB = 1'b1;
    repeat (4) tick();
    `CHK("midexec_idle_pc", pc, 8'h00)
    `CHK("midexec_idle_imm", imm, 4'h0)
    `CHK("midexec_idle_loadAcc", loadAcc, 1'b0)
    exp_pc  = 8'h00;
    exp_ill = 1'b0;
    start();
    run_instr(0, h);

    // Step 6: random programs with random acc_zero, restarting after a halt.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    do_reset();
    start();
    for (int n = 0; n < 200; n++) begin
      run_instr(-1, h);
      if (h) begin
        do_reset();
        start();
      end
    end

    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/acc_ctrl.md
# acc_ctrl

Multi-cycle control sequencer for the 8-bit accumulator datapath of the simple CPU. Fetches 8-bit instructions at `pc`, decodes them and drives the accumulator's `loadAcc`/`sel_acc`/`imm` controls, the ALU operation select and the register-file write strobe. Sits between instruction memory and the datapath (accumulator, ALU, register file) as the single owner of all datapath load strobes.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  system clock, rising-edge.
- `CLB`  in  1  reset, asynchronous, active-low.
- `run`  in  1  start request, sampled in IDLE.
- `instr_in`  in  8  instruction word at address `pc`, valid combinationally.
- `acc_zero`  in  1  accumulator == 0 flag from datapath.
- `pc`  out  8  program counter / instruction address.
- `loadAcc`  out  1  accumulator load strobe.
- `sel_acc`  out  2  accumulator source: 00 ALU, 10 register, 11 immediate.
- `imm`  out  4  immediate value to accumulator.
- `alu_op`  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- `reg_sel`  out  4  register-file index for read and write.
- `loadReg`  out  1  register-file write strobe (writes accumulator value).
- `halted`  out  1  high in HALT state.
- `illegal`  out  1  sticky undefined-opcode flag (see Configuration).

## Operation
- Instruction: `op = ir[7:4]`, `arg = ir[3:0]`.
- Opcodes: 0000 NOP; 0001 LDI (acc = arg); 0010 LDR (acc = R[arg]); 0011 STR (R[arg] = acc); 0100 ADD, 0101 SUB, 0110 AND, 0111 OR (acc = acc op R[arg]); 1000 JMP (pc = {4'b0000, arg}); 1001 JZ (jump as JMP if `acc_zero`, else pc+1); 1111 HLT; 1010–1110 undefined.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE: `run`=1 -> FETCH; else stay.
- FETCH: `ir <= instr_in`; -> DECODE.
- DECODE: HLT -> HALT; undefined with trap enabled -> HALT; all others -> EXEC.
- EXEC: strobes asserted per opcode; at end of cycle pc updated (jump target or pc+1); -> FETCH.
- HALT: absorbing; exit only by `CLB` low. `run` ignored outside IDLE.
- Outputs are Moore: functions of state and `ir` only, no combinational path from `run`/`instr_in`/`acc_zero`.
- In EXEC: LDI -> `loadAcc`=1, `sel_acc`=11, `imm`=arg; LDR -> `loadAcc`=1, `sel_acc`=10, `reg_sel`=arg; ALU ops -> `loadAcc`=1, `sel_acc`=00, `alu_op`=op[1:0], `reg_sel`=arg; STR -> `loadReg`=1, `reg_sel`=arg. NOP/JMP/JZ/undefined: no strobes.
- `loadAcc` and `loadReg` never high outside EXEC; never both high.
- `imm`, `reg_sel` driven from `ir[3:0]` in all states; `sel_acc`, `alu_op` 00 outside EXEC.
- pc+1 wraps 8'hFF -> 8'h00.

## Timing
- Reset (`CLB`=0, async, any state incl. mid-instruction): state IDLE, `pc`=0, `ir`=0, `illegal`=0; all strobes 0, `sel_acc`=00, `alu_op`=00, `imm`=0, `reg_sel`=0, `halted`=0.
- 3 cycles per instruction (FETCH, DECODE, EXEC); HLT retires in 2 (FETCH, DECODE).
- First FETCH is the cycle after `run` is sampled high in IDLE.
- Datapath captures on the rising edge ending EXEC; `acc_zero` sampled in EXEC reflects the accumulator before that edge.
- `pc` changes only on the edge ending EXEC; stable through FETCH/DECODE.
- `halted` rises the cycle after DECODE of HLT/trapped opcode.

## Configuration
- `ACC_CTRL_ILLEGAL_TRAP_EN` defined: undefined opcode in DECODE sets `illegal`=1 (sticky until reset) and enters HALT; `pc` stays at the trapping instruction.
- Not defined: undefined opcodes execute as NOP (EXEC, no strobes, pc+1); `illegal` tied 0.

## Test plan
- Reset then `run` pulse, program {0x15, 0x33, 0xF0}: LDI 5 `loadAcc`=1/`sel_acc`=11/`imm`=5 at cycle 3, STR `loadReg`=1/`reg_sel`=3 at cycle 6, `halted`=1 at cycle 9, `pc`=2.
- ADD/SUB/AND/OR on R2 (0x42..0x72): each EXEC shows `sel_acc`=00, `alu_op`=00..11, `reg_sel`=2, one-cycle `loadAcc`.
- JZ 0x9A with `acc_zero`=1 -> `pc`=0x0A; with `acc_zero`=0 -> `pc`=prev+1; JMP 0x87 -> `pc`=0x07.
- NOP at address 0xFF -> `pc` wraps to 0x00, no strobes.
- Opcode 0xA0: with macro `illegal`=1, `halted`=1, `pc` unchanged; without macro `pc`+1, `illegal`=0.
- Assert `CLB` low during EXEC of LDI: `loadAcc` drops immediately, `pc`=0, state IDLE; no progress until next `run`.
